// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: stock VGA timing sets (640x480@60, 320x240) and default counter width.
package vga_timing_pkg;
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;
  localparam vga_timing_t VGA_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_timing_t VGA_320X240 = '{320, 8, 48, 24, 240, 5, 1, 16};
  localparam int DEF_CNT_W = 11;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vga_timing_gen_pix_en_div.sv
// pix_en_div: divides clk by PIX_DIV into a one-cycle pixel strobe, held low during reset.
module pix_en_div import vga_timing_pkg::*; #(
  parameter int PIX_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);
  localparam int DW = clog2_min1(PIX_DIV);
  localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);
  logic [DW-1:0] div;
  always_ff @(posedge clk or posedge reset)
    if (reset) div <= '0;
    else div <= (div == LAST) ? '0 : div + 1'b1;
  assign pix_en = !reset && div == LAST;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/position generator; define VGA_FRAME_CNT_EN to add the frame_cnt port.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = VGA_640X480.h_active,
  parameter int H_FP     = VGA_640X480.h_fp,
  parameter int H_SYNC   = VGA_640X480.h_sync,
  parameter int H_BP     = VGA_640X480.h_bp,
  parameter int V_ACTIVE = VGA_640X480.v_active,
  parameter int V_FP     = VGA_640X480.v_fp,
  parameter int V_SYNC   = VGA_640X480.v_sync,
  parameter int V_BP     = VGA_640X480.v_bp,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PIX_DIV  = 1,
  parameter int FRAME_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             pix_en,
  output logic             line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic [FRAME_W-1:0] frame_cnt,
`endif
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (PIX_DIV < 1 || CNT_W < 1 || FRAME_W < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 ||
      H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cfg
    $error("vga_timing_gen: illegal parameter set");
  end
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [CNT_W-1:0] hc, vc;
  logic h_wrap, v_wrap;
  pix_en_div #(.PIX_DIV(PIX_DIV)) u_div (.clk(clk), .reset(reset), .pix_en(pix_en));
  assign h_wrap = pix_en && hc == H_LAST;
  assign v_wrap = h_wrap && vc == V_LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      hc <= h_wrap ? '0 : hc + 1'b1;
      if (h_wrap) vc <= v_wrap ? '0 : vc + 1'b1;
    end
`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) frame_cnt <= '0;
    else if (v_wrap) frame_cnt <= frame_cnt + 1'b1;
`endif
  // counters sit at 0 in reset, so only display_on needs explicit gating
  assign hsync       = (hc >= HS_BEG && hc <= HS_END) ? 1'(HS_POL) : ~1'(HS_POL);
  assign vsync       = (vc >= VS_BEG && vc <= VS_END) ? 1'(VS_POL) : ~1'(VS_POL);
  assign display_on  = !reset && hc < H_ACT && vc < V_ACT;
  assign hpos        = display_on ? hc : '0;
  assign vpos        = display_on ? vc : '0;
  assign line_start  = pix_en && hc == '0;
  assign frame_start = line_start && vc == '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random reset episodes on PIX_DIV=1 and PIX_DIV=3 instances vs. an arithmetic frame model.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic hs1, vs1, don1, pe1, ls1, fs1, hs3, vs3, don3, pe3, ls3, fs3;
  logic [4:0] hp1, vp1, hp3, vp3;
`ifdef VGA_FRAME_CNT_EN
  logic [1:0] fc1, fc3;
`endif
  int checks = 0;
  int failures = 0;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0), .CNT_W(5), .PIX_DIV(1), .FRAME_W(2)) dut1 (
    .clk(clk), .reset(reset), .hsync(hs1), .vsync(vs1), .display_on(don1), .hpos(hp1),
    .vpos(vp1), .pix_en(pe1), .line_start(ls1),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc1),
`endif
    .frame_start(fs1));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0), .CNT_W(5), .PIX_DIV(3), .FRAME_W(2)) dut3 (
    .clk(clk), .reset(reset), .hsync(hs3), .vsync(vs3), .display_on(don3), .hpos(hp3),
    .vpos(vp3), .pix_en(pe3), .line_start(ls3),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc3),
`endif
    .frame_start(fs3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // t = cycles since reset release; k = pixels already completed; 16x8 frame of 128 pixels
  function automatic logic [15:0] model(input int t, input int d);
    int k, hc, vc;
    logic pe, hs, vs, don, ls, fs;
    logic [4:0] hp, vp;
    k = t / d;
    hc = k % 16;
    vc = (k / 16) % 8;
    pe = (t % d) == d - 1;
    hs = !(hc >= 10 && hc <= 12);
    vs = !(vc >= 5 && vc <= 6);
    don = hc < 8 && vc < 4;
    ls = pe && hc == 0;
    fs = ls && vc == 0;
    hp = don ? 5'(hc) : 5'd0;
    vp = don ? 5'(vc) : 5'd0;
    return {hs, vs, don, pe, ls, fs, hp, vp};
  endfunction

  task automatic check_run(input int t);
    logic [15:0] e1, e3;
    e1 = model(t, 1);
    e3 = model(t, 3);
    chk("ctl_div1", 32'({hs1, vs1, don1, pe1, ls1, fs1}), 32'(e1[15:10]));
    chk("pos_div1", 32'({hp1, vp1}), 32'(e1[9:0]));
    chk("ctl_div3", 32'({hs3, vs3, don3, pe3, ls3, fs3}), 32'(e3[15:10]));
    chk("pos_div3", 32'({hp3, vp3}), 32'(e3[9:0]));
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_div1", 32'(fc1), 32'((t / 128) % 4));
    chk("fcnt_div3", 32'(fc3), 32'((t / 3 / 128) % 4));
`endif
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctl1"}, 32'({hs1, vs1, don1, pe1, ls1, fs1, hp1, vp1}), 32'({6'b110000, 10'd0}));
    chk({tag, "_ctl3"}, 32'({hs3, vs3, don3, pe3, ls3, fs3, hp3, vp3}), 32'({6'b110000, 10'd0}));
`ifdef VGA_FRAME_CNT_EN
    chk({tag, "_fcnt"}, 32'({fc1, fc3}), 32'd0);
`endif
  endtask

  initial begin
    int n, d;
    repeat (3) @(posedge clk);
    #1 check_idle("rst_init");
    for (int ep = 0; ep < 7; ep++) begin
      n = (ep == 0) ? 37 : int'($urandom_range(100, 900));
      @(posedge clk);
      #2 reset = 1'b0;
      for (int t = 0; t < n; t++) begin
        @(negedge clk);
        check_run(t);
      end
      @(posedge clk);
      #1 check_run(n);
      d = int'($urandom_range(0, 2));
      #(d) reset = 1'b1;
      #1 check_idle("rst_async");
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        check_idle("rst_hold");
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameters: H_FP, 16; H_SYNC, 96; H_BP, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters: V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33, vertical widths in lines.
REQ-004 SHALL have parameters: HS_POL, 0; VS_POL, 0, active level of hsync and vsync.
REQ-005 SHALL have parameters: CNT_W, 11, width of the counters and of hpos/vpos.
REQ-006 SHALL have parameters: PIX_DIV, 1, clk cycles per pixel.
REQ-007 SHALL have parameters: FRAME_W, 8, frame_cnt width.
REQ-008 SHALL have port clk  input  1  system clock; the design has one clock.
REQ-009 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-010 SHALL have port hsync, vsync  output  1 each  sync pulses at the programmed polarity.
REQ-011 SHALL have port display_on  output  1  high inside the active area.
REQ-012 SHALL have port hpos, vpos  output  CNT_W each  active-area coordinates, 0 outside the active area.
REQ-013 SHALL have port pix_en  output  1  pixel strobe.
REQ-014 SHALL have port line_start, frame_start  output  1 each  one-cycle pulses.
REQ-015 SHALL have port frame_cnt  output  FRAME_W  frame counter; the port exists only under VGA_FRAME_CNT_EN.

Function
REQ-016 Totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-017 Divider counter div SHALL count 0..PIX_DIV-1 and wrap; pix_en SHALL be high when div == PIX_DIV-1 (constantly high when PIX_DIV = 1).
REQ-018 hc SHALL advance only when pix_en is high; hc SHALL wrap from H_TOTAL-1 to 0.
REQ-019 vc SHALL increment exactly when hc wraps; vc SHALL wrap from V_TOTAL-1 to 0.
REQ-020 Line order SHALL be active [0, H_ACTIVE-1], then front porch, then sync, then back porch; vertical order SHALL match.
REQ-021 hsync SHALL equal HS_POL when hc is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and ~HS_POL otherwise.
REQ-022 vsync SHALL follow the same rule on vc with the V_* parameters and VS_POL.
REQ-023 display_on SHALL be (hc < H_ACTIVE) && (vc < V_ACTIVE).
REQ-024 hpos/vpos SHALL equal hc/vc while display_on is high, else 0.
REQ-025 line_start SHALL equal pix_en && hc == 0.
REQ-026 frame_start SHALL equal line_start && vc == 0.
REQ-027 All outputs SHALL be decodes of the current div/hc/vc registers; latency from a counter update to the outputs SHALL be 0 cycles.
REQ-028 Elaboration SHALL fail if PIX_DIV < 1, if any width parameter is 0, or if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1.

Reset
REQ-029 While reset is high, div, hc, vc and frame_cnt SHALL be 0.
REQ-030 While reset is high, outputs SHALL be inactive: hsync=~HS_POL, vsync=~VS_POL, display_on=0, hpos=vpos=0, pix_en=line_start=frame_start=0.
REQ-031 Reset asserted mid-frame SHALL take effect asynchronously.
REQ-032 After reset release, the first pix_en cycle SHALL present hc=vc=0 with frame_start=1.

Configuration
REQ-033 With VGA_FRAME_CNT_EN defined, frame_cnt SHALL increment modulo 2^FRAME_W on each cycle where vc and hc both wrap to 0 (the cycle before the next frame_start).
REQ-034 Without VGA_FRAME_CNT_EN, the frame_cnt port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-035 Package vga_timing_pkg SHALL hold 640x480@60 default timing constants, a 320x240 timing constant set, and the default CNT_W.
REQ-036 The pixel divider SHALL be a sub-module pix_en_div (parameter PIX_DIV; ports clk, reset, pix_en).

Verification (H 8/2/3/3 = 16, V 4/1/2/1 = 8, CNT_W=5, polarities 0)
REQ-037 Reset release, PIX_DIV=1 -> first cycle: frame_start=1, line_start=1, display_on=1, hpos=vpos=0; cycle 8: display_on=0.
REQ-038 Horizontal sync -> hsync low exactly at hc 10..12 of every line; vsync low exactly during vc 5..6, i.e. 32 cycles per frame.
REQ-039 Wrap-around -> hc 15 to 0 increments vc; at vc=7, hc=15 both wrap and the next cycle has frame_start=1; frame period is 128 cycles.
REQ-040 PIX_DIV=3 -> pix_en high on cycles 2, 5, 8, ... after release; hc steps only then; frame period is 384 cycles.
REQ-041 Reset at hc=5, vc=2 -> outputs go inactive in the same cycle without a clk edge; after release the frame restarts at 0,0.
REQ-042 VGA_FRAME_CNT_EN with FRAME_W=2 -> frame_cnt reads 1, 2, 3, 0 after 1, 2, 3, 4 frames; without the macro, the build has no frame_cnt port.
